// File: rtl/mm_word_serial.sv
// mm_word_serial: word-serial Montgomery multiplier, Z = X*Y*2^-N_BITS mod P.
// One W-bit word of X is consumed per iteration. The default build runs each
// iteration as two states (MUL then RED), for a latency of 2K+1. Defining
// MM_FAST_EN merges MUL and RED into one state, for a latency of K+1.
// Ports:
//   clk          - sole clock, rising edge
//   rst          - synchronous active-high reset
//   start        - request an operation (sampled only in IDLE)
//   multiplier   - X, N_BITS
//   multiplicand - Y, N_BITS
//   modulus      - P (odd), N_BITS
//   mp           - -P^-1 mod 2^W
//   result       - Z, registered, held until the next completion
//   busy         - high while an operation is in progress
//   end_flag     - one-cycle pulse when result is updated
module mm_word_serial #(
    parameter int unsigned N_BITS = 256,
    parameter int unsigned W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] multiplier,
    input  logic [N_BITS-1:0] multiplicand,
    input  logic [N_BITS-1:0] modulus,
    input  logic [W-1:0]      mp,
    output logic [N_BITS-1:0] result,
    output logic              busy,
    output logic              end_flag
);

    localparam int unsigned K  = N_BITS / W;
    localparam int unsigned AW = N_BITS + W + 2;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
`ifndef MM_FAST_EN
    localparam logic [1:0] S_RED   = 2'd2;
`endif
    localparam logic [1:0] S_FINAL = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [N_BITS-1:0] r_x;
    logic [N_BITS-1:0] r_y;
    logic [N_BITS-1:0] r_p;
    logic [W-1:0]      r_mp;
    logic [AW-1:0]     r_t;
    logic [IW-1:0]     r_idx;

    logic [AW-1:0]     w_xy;
    logic [W-1:0]      w_q;
    logic [AW-1:0]     w_t_red;
    logic              w_last;

    // r_x is shifted right after each word is used, so x_i is always the low word
    assign w_xy   = AW'(r_x[W-1:0]) * AW'(r_y);
    assign w_last = (r_idx == IW'(K - 1));

`ifdef MM_FAST_EN
    logic [AW-1:0] w_sum;

    // Merged step: q is derived from the low word of T + x_i*Y
    assign w_sum   = r_t + w_xy;
    assign w_q     = w_sum[W-1:0] * r_mp;
    assign w_t_red = (w_sum + AW'(w_q) * AW'(r_p)) >> W;
`else
    logic [AW-1:0] w_t_mul;

    assign w_t_mul = r_t + w_xy;
    assign w_q     = r_t[W-1:0] * r_mp;
    assign w_t_red = (r_t + AW'(w_q) * AW'(r_p)) >> W;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_MUL;
`ifdef MM_FAST_EN
            S_MUL:   w_state_nxt = w_last ? S_FINAL : S_MUL;
`else
            S_MUL:   w_state_nxt = S_RED;
            S_RED:   w_state_nxt = w_last ? S_FINAL : S_MUL;
`endif
            S_FINAL: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_p      <= '0;
            r_mp     <= '0;
            r_t      <= '0;
            r_idx    <= '0;
            result   <= '0;
            busy     <= 1'b0;
            end_flag <= 1'b0;
        end else begin
            end_flag <= 1'b0;
            busy     <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x   <= multiplier;
                        r_y   <= multiplicand;
                        r_p   <= modulus;
                        r_mp  <= mp;
                        r_t   <= '0;
                        r_idx <= '0;
                    end
                end
`ifdef MM_FAST_EN
                S_MUL: begin
                    r_t <= w_t_red;
                    r_x <= r_x >> W;
                    if (!w_last) r_idx <= r_idx + IW'(1);
                end
`else
                S_MUL: begin
                    r_t <= w_t_mul;
                    r_x <= r_x >> W;
                end
                S_RED: begin
                    r_t <= w_t_red;
                    if (!w_last) r_idx <= r_idx + IW'(1);
                end
`endif
                S_FINAL: begin
                    // T < 2P here, so a single conditional subtract suffices
                    result   <= (r_t >= AW'(r_p)) ? N_BITS'(r_t - AW'(r_p)) : N_BITS'(r_t);
                    end_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
